rob_multi_wb: RTL and testbench



---
 rtl/rob_multi_wb.sv | 151 +++++++++++++++
 tb/tb_rob_multi_wb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi_wb.sv
// Reorder buffer with ALU and SLB writeback ports; commits in order, one per cycle, and flushes on branch mispredict.
// Latency: writeback to commit is 1 cycle; with ROB_WB_BYPASS_EN defined, a head writeback commits at the same edge.
// Backpressure: issue_ready is low when full or during a flush decision; a head store waits for store_commit_ready.
module rob_multi_wb #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DATA_W     = 32,
  parameter int RD_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  output logic [DEPTH_LOG2-1:0] issue_tag,
  input  logic [DATA_W-1:0]     issue_pc,
  input  logic [DATA_W-1:0]     issue_pred_pc,
  input  logic [RD_W-1:0]       issue_rd,
  input  logic                  issue_is_store,
  input  logic                  issue_is_branch,
  input  logic                  alu_wb_valid,
  input  logic [DEPTH_LOG2-1:0] alu_wb_tag,
  input  logic [DATA_W-1:0]     alu_wb_data,
  input  logic [DATA_W-1:0]     alu_wb_jpc,
  input  logic                  slb_wb_valid,
  input  logic [DEPTH_LOG2-1:0] slb_wb_tag,
  input  logic [DATA_W-1:0]     slb_wb_data,
  input  logic                  store_commit_ready,
  output logic                  commit_valid,
  output logic [DEPTH_LOG2-1:0] commit_tag,
  output logic [DATA_W-1:0]     commit_pc,
  output logic [RD_W-1:0]       commit_rd,
  output logic [DATA_W-1:0]     commit_data,
  output logic                  store_commit_valid,
  output logic                  flush_valid,
  output logic [DATA_W-1:0]     flush_pc,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH-1:0]      ent_done;
  logic [DEPTH-1:0]      ent_store;
  logic [DEPTH-1:0]      ent_branch;
  logic [DATA_W-1:0]     ent_pc      [DEPTH];
  logic [DATA_W-1:0]     ent_pred_pc [DEPTH];
  logic [DATA_W-1:0]     ent_data    [DEPTH];
  logic [DATA_W-1:0]     ent_jpc     [DEPTH];
  logic [RD_W-1:0]       ent_rd      [DEPTH];
  logic [DEPTH_LOG2-1:0] head;
  logic [DEPTH_LOG2-1:0] tail;

  logic                  head_done;
  logic [DATA_W-1:0]     head_data;
  logic [DATA_W-1:0]     head_jpc;
  logic                  commit;
  logic                  mispredict;
  logic                  fire;

`ifdef ROB_WB_BYPASS_EN
  logic alu_hit_head;
  logic slb_hit_head;

  assign alu_hit_head = alu_wb_valid && (alu_wb_tag == head);
  assign slb_hit_head = slb_wb_valid && (slb_wb_tag == head);
  assign head_done    = ent_done[head] | alu_hit_head | slb_hit_head;
  assign head_data    = alu_hit_head ? alu_wb_data :
                        slb_hit_head ? slb_wb_data : ent_data[head];
  assign head_jpc     = alu_hit_head ? alu_wb_jpc : ent_jpc[head];
`else
  assign head_done = ent_done[head];
  assign head_data = ent_data[head];
  assign head_jpc  = ent_jpc[head];
`endif

  assign commit      = ent_valid[head] && head_done && (!ent_store[head] || store_commit_ready);
  assign mispredict  = commit && ent_branch[head] && (head_jpc != ent_pred_pc[head]);
  // Issue is refused on the mispredict edge because that edge discards it anyway.
  assign issue_ready = (count < FULL) && !mispredict;
  assign issue_tag   = tail;
  assign fire        = issue_valid && issue_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_valid          <= '0;
      ent_done           <= '0;
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      commit_valid       <= 1'b0;
      store_commit_valid <= 1'b0;
      flush_valid        <= 1'b0;
      commit_tag         <= '0;
      commit_pc          <= '0;
      commit_rd          <= '0;
      commit_data        <= '0;
      flush_pc           <= '0;
    end else begin
      commit_valid       <= commit;
      store_commit_valid <= commit && ent_store[head];
      flush_valid        <= mispredict;
      if (commit) begin
        commit_tag  <= head;
        commit_pc   <= ent_pc[head];
        commit_rd   <= ent_rd[head];
        commit_data <= head_data;
      end
      if (mispredict) begin
        flush_pc  <= head_jpc;
        ent_valid <= '0;
        ent_done  <= '0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
      end else begin
        if (slb_wb_valid && ent_valid[slb_wb_tag]) ent_done[slb_wb_tag] <= 1'b1;
        if (alu_wb_valid && ent_valid[alu_wb_tag]) ent_done[alu_wb_tag] <= 1'b1;
        if (commit) begin
          ent_valid[head] <= 1'b0;
          head            <= head + PTR_ONE;
        end
        // Tail never equals a committing head here: issue is blocked when full.
        if (fire) begin
          ent_valid[tail] <= 1'b1;
          ent_done[tail]  <= 1'b0;
          tail            <= tail + PTR_ONE;
        end
        count <= count + CNT_W'(fire) - CNT_W'(commit);
      end
    end
  end

  // Payload needs no reset: every read is qualified by ent_valid/ent_done.
  always_ff @(posedge clk) begin
    if (fire) begin
      ent_pc[tail]      <= issue_pc;
      ent_pred_pc[tail] <= issue_pred_pc;
      ent_rd[tail]      <= issue_rd;
      ent_store[tail]   <= issue_is_store;
      ent_branch[tail]  <= issue_is_branch;
    end
    if (slb_wb_valid && ent_valid[slb_wb_tag]) ent_data[slb_wb_tag] <= slb_wb_data;
    if (alu_wb_valid && ent_valid[alu_wb_tag]) begin
      ent_data[alu_wb_tag] <= alu_wb_data;
      ent_jpc[alu_wb_tag]  <= alu_wb_jpc;
    end
  end

endmodule

// File: tb/tb_rob_multi_wb.sv
// Directed bench for rob_multi_wb (default build, 8 entries): fill, out-of-order completion,
// wrap-around streaming, store handshake, mispredict flush and same-tag writeback collision.
module tb_rob_multi_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic [31:0] issue_pc;
  logic [31:0] issue_pred_pc;
  logic [4:0]  issue_rd;
  logic        issue_is_store;
  logic        issue_is_branch;
  logic        alu_wb_valid;
  logic [2:0]  alu_wb_tag;
  logic [31:0] alu_wb_data;
  logic [31:0] alu_wb_jpc;
  logic        slb_wb_valid;
  logic [2:0]  slb_wb_tag;
  logic [31:0] slb_wb_data;
  logic        store_commit_ready;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic [31:0] commit_pc;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic        store_commit_valid;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  rob_multi_wb #(.DEPTH_LOG2(3), .DATA_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .issue_pc(issue_pc), .issue_pred_pc(issue_pred_pc), .issue_rd(issue_rd),
    .issue_is_store(issue_is_store), .issue_is_branch(issue_is_branch),
    .alu_wb_valid(alu_wb_valid), .alu_wb_tag(alu_wb_tag), .alu_wb_data(alu_wb_data),
    .alu_wb_jpc(alu_wb_jpc),
    .slb_wb_valid(slb_wb_valid), .slb_wb_tag(slb_wb_tag), .slb_wb_data(slb_wb_data),
    .store_commit_ready(store_commit_ready),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_data(commit_data),
    .store_commit_valid(store_commit_valid),
    .flush_valid(flush_valid), .flush_pc(flush_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    issue_valid        = 1'b0;
    issue_is_store     = 1'b0;
    issue_is_branch    = 1'b0;
    alu_wb_valid       = 1'b0;
    slb_wb_valid       = 1'b0;
    store_commit_ready = 1'b0;
  endtask

  task automatic do_issue(input logic [31:0] pc, input logic [31:0] pred,
                          input logic [4:0] rd, input logic st, input logic br);
    issue_valid     = 1'b1;
    issue_pc        = pc;
    issue_pred_pc   = pred;
    issue_rd        = rd;
    issue_is_store  = st;
    issue_is_branch = br;
  endtask

  task automatic do_alu(input logic [2:0] tag, input logic [31:0] data, input logic [31:0] jpc);
    alu_wb_valid = 1'b1;
    alu_wb_tag   = tag;
    alu_wb_data  = data;
    alu_wb_jpc   = jpc;
  endtask

  task automatic do_slb(input logic [2:0] tag, input logic [31:0] data);
    slb_wb_valid = 1'b1;
    slb_wb_tag   = tag;
    slb_wb_data  = data;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    issue_pc = '0; issue_pred_pc = '0; issue_rd = '0;
    alu_wb_tag = '0; alu_wb_data = '0; alu_wb_jpc = '0;
    slb_wb_tag = '0; slb_wb_data = '0;

    // Reset state
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_store_commit_valid", store_commit_valid, 0);
    chk("rst_flush_valid", flush_valid, 0);
    chk("rst_flush_pc", flush_pc, 0);
    chk("rst_commit_data", commit_data, 0);
    chk("rst_commit_pc", commit_pc, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_issue_tag", issue_tag, 0);

    // Fill all 8 entries with no writebacks
    for (int i = 0; i < 8; i++) begin
      do_issue(32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), 5'(i + 1), 1'b0, 1'b0);
      #1;
      chk("fill_tag", issue_tag, i);
      chk("fill_ready", issue_ready, 1);
      tick();
    end
    clr();
    #1;
    chk("full_count", count, 8);
    chk("full_ready", issue_ready, 0);
    chk("full_no_commit", commit_valid, 0);
    // Commit from a full buffer does not reopen issue in the same cycle
    do_alu(3'd0, 32'h1, 32'h104);
    tick();
    clr();
    issue_valid = 1'b1;
    #1;
    chk("full_commit_ready", issue_ready, 0);
    tick();
    clr();
    chk("full_commit_valid", commit_valid, 1);
    chk("full_commit_tag", commit_tag, 0);
    chk("full_after_count", count, 7);
    chk("full_after_ready", issue_ready, 1);

    // Out-of-order completion
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_issue(32'h200 + 32'(4 * i), 32'h204 + 32'(4 * i), 5'(i + 1), 1'b0, 1'b0);
      tick();
    end
    clr();
    chk("ooo_count", count, 3);
    do_alu(3'd2, 32'h22, 32'hDEAD);
    tick();
    clr();
    chk("ooo_nocommit_a", commit_valid, 0);
    do_slb(3'd0, 32'h00AA);
    tick();
    clr();
    chk("ooo_nocommit_b", commit_valid, 0);
    do_alu(3'd1, 32'h11, 32'hBEEF);
    tick();
    clr();
    chk("ooo_c0_valid", commit_valid, 1);
    chk("ooo_c0_tag", commit_tag, 0);
    chk("ooo_c0_data", commit_data, 32'h00AA);
    chk("ooo_c0_rd", commit_rd, 1);
    tick();
    chk("ooo_c1_valid", commit_valid, 1);
    chk("ooo_c1_tag", commit_tag, 1);
    chk("ooo_c1_data", commit_data, 32'h11);
    chk("ooo_c1_pc", commit_pc, 32'h204);
    chk("ooo_c1_noflush", flush_valid, 0);
    tick();
    chk("ooo_c2_valid", commit_valid, 1);
    chk("ooo_c2_tag", commit_tag, 2);
    chk("ooo_c2_data", commit_data, 32'h22);
    chk("ooo_c2_noflush", flush_valid, 0);
    tick();
    chk("ooo_idle_valid", commit_valid, 0);
    chk("ooo_idle_count", count, 0);

    // Wrap-around: head=tail=3 now; fill 4 entries (tags 3..6), complete head
    for (int i = 0; i < 4; i++) begin
      do_issue(32'h300 + 32'(4 * i), 32'h304 + 32'(4 * i), 5'd7, 1'b0, 1'b0);
      tick();
    end
    clr();
    do_alu(3'd3, 32'h1000, 32'h0);
    tick();
    clr();
    chk("wrap_pre_count", count, 4);
    for (int k = 0; k < 20; k++) begin
      do_issue(32'h400 + 32'(4 * k), 32'h404 + 32'(4 * k), 5'd9, 1'b0, 1'b0);
      do_alu(3'((4 + k) % 8), 32'h1000 + 32'(k + 1), 32'h0);
      #1;
      chk("wrap_issue_tag", issue_tag, (7 + k) % 8);
      chk("wrap_issue_ready", issue_ready, 1);
      tick();
      chk("wrap_commit_valid", commit_valid, 1);
      chk("wrap_commit_tag", commit_tag, (3 + k) % 8);
      chk("wrap_commit_data", commit_data, 32'h1000 + 32'(k));
      chk("wrap_count", count, 4);
    end
    clr();

    // Store handshake
    do_reset();
    do_issue(32'h500, 32'h504, 5'd0, 1'b1, 1'b0);
    tick();
    clr();
    do_slb(3'd0, 32'h77);
    tick();
    clr();
    do_issue(32'h504, 32'h508, 5'd3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      clr();
      chk("st_stall_valid", commit_valid, 0);
      chk("st_stall_sv", store_commit_valid, 0);
    end
    chk("st_stall_count", count, 2);
    store_commit_ready = 1'b1;
    tick();
    clr();
    chk("st_commit_valid", commit_valid, 1);
    chk("st_commit_sv", store_commit_valid, 1);
    chk("st_commit_tag", commit_tag, 0);
    chk("st_commit_data", commit_data, 32'h77);
    tick();
    chk("st_after_valid", commit_valid, 0);
    chk("st_after_sv", store_commit_valid, 0);
    chk("st_after_count", count, 1);

    // Misprediction flush
    do_reset();
    do_issue(32'h0FC, 32'h100, 5'd1, 1'b0, 1'b0);
    tick();
    do_issue(32'h100, 32'h104, 5'd0, 1'b0, 1'b1);
    tick();
    do_issue(32'h104, 32'h108, 5'd2, 1'b0, 1'b0);
    tick();
    do_issue(32'h108, 32'h10C, 5'd3, 1'b0, 1'b0);
    tick();
    clr();
    chk("mp_count", count, 4);
    do_alu(3'd0, 32'h1, 32'h0);
    tick();
    clr();
    do_alu(3'd1, 32'h104, 32'h200);
    tick();
    clr();
    chk("mp_c0_tag", commit_tag, 0);
    chk("mp_c0_noflush", flush_valid, 0);
    do_slb(3'd2, 32'h33);
    issue_valid = 1'b1;
    #1;
    chk("mp_issue_ready", issue_ready, 0);
    tick();
    clr();
    chk("mp_flush_valid", flush_valid, 1);
    chk("mp_flush_pc", flush_pc, 32'h200);
    chk("mp_commit_valid", commit_valid, 1);
    chk("mp_commit_tag", commit_tag, 1);
    chk("mp_count_zero", count, 0);
    chk("mp_issue_tag", issue_tag, 0);
    tick();
    chk("mp_flush_pulse", flush_valid, 0);
    chk("mp_commit_pulse", commit_valid, 0);
    do_issue(32'h200, 32'h204, 5'd4, 1'b0, 1'b0);
    tick();
    clr();
    chk("mp_reissue_count", count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mp_no_stale_commit", commit_valid, 0);
    end

    // Same-tag collision: ALU wins
    do_reset();
    do_issue(32'h600, 32'h604, 5'd5, 1'b0, 1'b0);
    tick();
    clr();
    do_alu(3'd0, 32'h5, 32'h604);
    do_slb(3'd0, 32'h9);
    tick();
    clr();
    chk("col_pre_valid", commit_valid, 0);
    tick();
    chk("col_commit_valid", commit_valid, 1);
    chk("col_commit_data", commit_data, 32'h5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
